instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of instructionDecoder. Owns the program counter,
//  fetches one 32-bit word per instruction from instruction memory over a req/ready
//  handshake, and holds it stable on instr for the decoder.
//  On advance, computes the next PC from the decoder's pcSrc selection and the
//  branch/register inputs from the datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; first fetch address
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  byte address of fetch (= pc)
//  imem_ready   in   1   memory accepts request and returns imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  registered instruction to decoder
//  instr_valid  out  1   instr holds a fetched, unconsumed instruction
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc + 4 (mod 2^32); used for jal link value
//  advance      in   1   datapath finished current instruction; take next PC
//  pc_src       in   2   0 pc+4, 1 reg indirect, 2 jump absolute, 3 branch
//  branch_taken in   1   branch condition result; used only when pc_src==3
//  reg_target   in   32  rs value; jr target when pc_src==1
//  halt         in   1   syscall/stop; freeze fetch after current instruction
//  fault        out  1   sticky: misaligned next-PC detected
// BEHAVIOUR
//  Reset (async, rst_n low): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0,
//   state=REQ. All outputs take reset values immediately, including mid-request.
//  States: REQ, HOLD, HALTED.
//  REQ: imem_req=1, imem_addr=pc, held stable until imem_ready.
//   - On imem_ready: instr<=imem_rdata, instr_valid<=1, go to HOLD.
//   - Latency: first request in the first clk after rst_n deasserts. Zero wait states
//     gives instr_valid in the cycle after the request cycle.
//  HOLD: imem_req=0. instr, pc and instr_valid are stable.
//   - advance=1 and halt=0: pc<=next_pc, instr_valid<=0, go to REQ.
//   - halt=1 (with or without advance): instr_valid<=0, go to HALTED; pc unchanged.
//  HALTED: imem_req=0, instr_valid=0. Leave only via reset.
//  Inputs ignored outside HOLD: advance, pc_src, branch_taken, reg_target, halt.
//  imem_ready is ignored unless imem_req=1.
//  next_pc (32-bit, all sums mod 2^32):
//   - pc_src 0: pc_plus4.
//   - pc_src 1: reg_target.
//   - pc_src 2: {pc_plus4[31:28], instr[25:0], 2'b00}.
//   - pc_src 3: branch_taken ? pc_plus4 + (sign_ext(instr[15:0]) << 2) : pc_plus4.
//  Alignment: if next_pc[1:0] != 0 on advance, then fault<=1, go to HALTED, pc unchanged.
//   Only pc_src 1 can produce this.
//  Wrap: pc=32'hFFFF_FFFC with pc_src 0 gives next pc 32'h0000_0000; no fault.
// TESTING
//  1. Hold rst_n=0, then release -> next cycle imem_req=1, imem_addr=0x0,
//     instr_valid=0, fault=0.
//  2. imem_ready=1, rdata=0x2008_0005 -> instr=0x2008_0005, instr_valid=1.
//     Then advance, pc_src=0 -> imem_addr=0x4.
//  3. pc=0x10, instr imm=0xFFFC, pc_src=3:
//     branch_taken=1 -> next fetch 0x04; branch_taken=0 -> next fetch 0x14.
//  4. pc=0x0040_0000, instr=0x0800_0010, pc_src=2 -> next 0x0000_0040.
//     pc_src=1, reg_target=0x1003 -> fault=1, imem_req stays 0.
//  5. imem_ready low for 3 cycles -> imem_req and imem_addr held, instr_valid=0.
//     pc=0xFFFF_FFFC, pc_src=0 -> next fetch 0x0.
//  6. halt=1 with advance=1 -> HALTED, no further imem_req.
//     rst_n low during REQ wait state -> imem_req=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over a req/ready
// handshake and holds it for the decoder until the datapath advances.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  input  logic        halt,
  output logic        fault
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, pc4, br_off;
  logic        valid_q, valid_d, req_q, fault_q, fault_d;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (pc_src)
      2'd0:    next_pc = pc4;
      2'd1:    next_pc = reg_target;
      2'd2:    next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
      default: next_pc = branch_taken ? (pc4 + br_off) : pc4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ: begin
        // req_q is low in the first cycle after reset, so a stray ready is ignored
        if (req_q && imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (halt) begin
          valid_d = 1'b0;
          state_d = S_HALTED;
        end else if (advance) begin
          valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALTED: valid_d = 1'b0;
      default:  state_d = S_HALTED;
    endcase
  end

  // Request is registered from the next state so it drops to 0 on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= (state_d == S_REQ);
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc4;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of fetch/advance vectors plus
// hand-written wait-state, fault, async-reset and halt sequences.
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, instr_valid, advance, branch_taken, halt, fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, reg_target;
  logic [1:0]  pc_src;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .pc_src(pc_src), .branch_taken(branch_taken),
    .reg_target(reg_target), .halt(halt), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] rtgt;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("wait_req", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_rdata = word;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic step(input logic [1:0] src, input logic taken, input logic [31:0] rt, input logic h);
    advance = 1'b1; pc_src = src; branch_taken = taken; reg_target = rt; halt = h;
    tick();
    advance = 1'b0; pc_src = 2'd0; branch_taken = 1'b0; reg_target = '0; halt = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    vecs[0] = '{32'h2008_0005, 2'd0, 1'b0, 32'h0,         32'h0000_0004};
    vecs[1] = '{32'h0000_0000, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_0010};
    vecs[2] = '{32'h1000_FFFC, 2'd3, 1'b1, 32'h0,         32'h0000_0004};
    vecs[3] = '{32'h0000_0000, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_0010};
    vecs[4] = '{32'h1000_FFFC, 2'd3, 1'b0, 32'h0,         32'h0000_0014};
    vecs[5] = '{32'h0000_0000, 2'd1, 1'b0, 32'h0040_0000, 32'h0040_0000};
    vecs[6] = '{32'h0800_0010, 2'd2, 1'b0, 32'h0,         32'h0000_0040};
    vecs[7] = '{32'h0000_0000, 2'd1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0000, 2'd0, 1'b0, 32'h0,         32'h0000_0000};

    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    advance = 1'b0; pc_src = 2'd0; branch_taken = 1'b0; reg_target = '0; halt = 1'b0;
    repeat (3) tick();
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'h0);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'd0);
    chk("first_fault", {31'b0, fault}, 32'd0);

    cur = 32'h0;
    for (int i = 0; i < 9; i++) begin
      wait_req();
      chk($sformatf("v%0d_addr", i), imem_addr, cur);
      fetch(vecs[i].rdata);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
      chk($sformatf("v%0d_pc", i), pc, cur);
      chk($sformatf("v%0d_pc4", i), pc_plus4, cur + 32'd4);
      chk($sformatf("v%0d_req_hold", i), {31'b0, imem_req}, 32'd0);
      step(vecs[i].src, vecs[i].taken, vecs[i].rtgt, 1'b0);
      chk($sformatf("v%0d_next_req", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("v%0d_next_addr", i), imem_addr, vecs[i].exp_next);
      chk($sformatf("v%0d_next_valid", i), {31'b0, instr_valid}, 32'd0);
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, 32'd0);
      cur = vecs[i].exp_next;
    end

    // wait states at pc 0: request and address held
    for (int w = 0; w < 3; w++) begin
      imem_rdata = 32'h1234_5678 + w;
      tick();
      chk("ws_req", {31'b0, imem_req}, 32'd1);
      chk("ws_addr", imem_addr, 32'h0);
      chk("ws_valid", {31'b0, instr_valid}, 32'd0);
    end

    // misaligned jr target
    fetch(32'h0000_0008);
    chk("ws_instr", instr, 32'h0000_0008);
    step(2'd1, 1'b0, 32'h0000_1003, 1'b0);
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("fault_req", {31'b0, imem_req}, 32'd0);
    chk("fault_pc", pc, 32'h0);
    imem_ready = 1'b1;
    repeat (3) tick();
    imem_ready = 1'b0;
    chk("fault_sticky", {31'b0, fault}, 32'd1);
    chk("fault_req_stays", {31'b0, imem_req}, 32'd0);
    chk("fault_valid", {31'b0, instr_valid}, 32'd0);

    rst_n = 1'b0;
    #1;
    chk("rst_fault_clr", {31'b0, fault}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wait_req();
    fetch(32'h0000_0000);
    step(2'd0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_addr", imem_addr, 32'h4);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);

    // async reset in the middle of a stalled request
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);

    // halt together with advance
    fetch(32'h0000_000C);
    step(2'd0, 1'b0, 32'h0, 1'b1);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_pc", pc, 32'h0);
    imem_ready = 1'b1;
    advance = 1'b1;
    repeat (4) tick();
    imem_ready = 1'b0;
    advance = 1'b0;
    chk("halted_req", {31'b0, imem_req}, 32'd0);
    chk("halted_pc", pc, 32'h0);
    chk("halted_fault", {31'b0, fault}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
